// File: rtl/bcm_framebuffer.sv
// ---------------------------------------------------------------------------
// bcm_framebuffer
//
// Double-buffered 64x64 RGB framebuffer feeding a binary-code-modulation LED
// driver. The host writes pixels into the back bank; the display side reads
// the front bank every cycle and turns each colour channel into a 1-bit
// on/off decision for the current subframe. A swap request exchanges the
// banks at the next frame boundary reported by the LED driver. A clear
// request zero-fills the back bank one word per cycle.
//
// Parameters
//   DEPTH      bits per colour channel (1..8)
//
// Ports
//   clk        single clock (LED driver pixel clock)
//   reset      synchronous, active-high
//   wr_valid   host pixel write request
//   wr_ready   write accepted this cycle (IDLE only, low in reset)
//   wr_x/wr_y  write column/row
//   wr_rgb     {blue, green, red}, DEPTH bits each
//   clr_req    pulse: zero-fill the back bank
//   swap_req   pulse: exchange front/back at the next frame boundary
//   swap_done  pulse in the cycle the swap takes effect
//   frame      frame counter from the LED driver
//   subframe   subframe counter from the LED driver
//   x/y        display read column/row
//   rgb        registered {blu, grn, red} on/off bits, latency 1
// ---------------------------------------------------------------------------
module bcm_framebuffer #(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [5:0]         wr_x,
   input  logic [5:0]         wr_y,
   input  logic [3*DEPTH-1:0] wr_rgb,
   input  logic               clr_req,
   input  logic               swap_req,
   output logic               swap_done,
   input  logic [12:0]        frame,
   input  logic [7:0]         subframe,
   input  logic [5:0]         x,
   input  logic [5:0]         y,
   output logic [2:0]         rgb
);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SWAP_WAIT
   } state_t;

   localparam int PW = 3 * DEPTH;

   state_t      state, state_n;
   logic        front_sel;
   logic [11:0] clr_cnt;
   logic [12:0] frame_q;
   logic        frame_edge;
   logic        swap_fire;

   // Two banks, addressed {bank, y, x}. No reset: contents survive reset.
   logic [PW-1:0] mem [0:8191];

   logic          wr_fire;
   logic          clearing;
   logic          mem_we;
   logic [12:0]   mem_addr;
   logic [PW-1:0] mem_wdata;
   logic [PW-1:0] rd_data;
   logic [2:0]    pix_on;

   // Subframe bits above DEPTH-1 are intentionally ignored.
   logic unused_subframe;
   assign unused_subframe = ^subframe;

   assign frame_edge = (frame != frame_q);

   // ------------------------------------------------------------------
   // Control FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_n   = state;
      swap_fire = 1'b0;
      case (state)
         IDLE: begin
            // Clear takes priority; a simultaneous swap request is dropped.
            if (clr_req)
               state_n = CLEAR;
            else if (swap_req)
               state_n = SWAP_WAIT;
         end
         CLEAR: begin
            if (clr_cnt == 12'hFFF)
               state_n = IDLE;
         end
         SWAP_WAIT: begin
            // frame_q was loaded while we were still in IDLE, so a boundary
            // coinciding with the request cycle is not seen here.
            if (frame_edge) begin
               state_n   = IDLE;
               swap_fire = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign wr_ready  = (state == IDLE) && !reset;
   assign swap_done = swap_fire && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         front_sel <= 1'b0;
         clr_cnt   <= 12'd0;
         frame_q   <= 13'd0;
      end else begin
         state   <= state_n;
         frame_q <= frame;
         if (swap_fire)
            front_sel <= ~front_sel;
         // Counter wraps 4095 -> 0 on the last clear cycle.
         if (state == CLEAR)
            clr_cnt <= clr_cnt + 12'd1;
         else
            clr_cnt <= 12'd0;
      end
   end

   // ------------------------------------------------------------------
   // Back-bank write port: host write or clear fill (mutually exclusive)
   // ------------------------------------------------------------------
   assign wr_fire   = wr_valid && wr_ready;
   // Gate with reset so a reset landing mid-clear writes nothing further.
   assign clearing  = (state == CLEAR) && !reset;
   assign mem_we    = wr_fire || clearing;
   assign mem_addr  = clearing ? {~front_sel, clr_cnt} : {~front_sel, wr_y, wr_x};
   assign mem_wdata = clearing ? '0 : wr_rgb;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   // ------------------------------------------------------------------
   // Front-bank read and BCM compare. The read is combinational so the
   // registered rgb lands one clock after x/y/subframe.
   // ------------------------------------------------------------------
   assign rd_data = mem[{front_sel, y, x}];

   for (genvar c = 0; c < 3; c++) begin : g_chan
      assign pix_on[c] = rd_data[c*DEPTH +: DEPTH] > subframe[DEPTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset)
         rgb <= 3'b000;
      else
         rgb <= pix_on;
   end

endmodule

// File: tb/tb_bcm_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_bcm_framebuffer
//
// Self-checking bench for bcm_framebuffer (DEPTH=4). Keeps a reference
// model of both banks and the front selection; expected rgb values are
// queued when a read is driven and compared when the registered output
// appears one clock later.
// ---------------------------------------------------------------------------
module tb_bcm_framebuffer;

   localparam int D  = 4;
   localparam int PW = 3 * D;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic          wr_ready;
   logic [5:0]    wr_x, wr_y;
   logic [PW-1:0] wr_rgb;
   logic          clr_req, swap_req, swap_done;
   logic [12:0]   frame;
   logic [7:0]    subframe;
   logic [5:0]    x, y;
   logic [2:0]    rgb;

   bcm_framebuffer #(.DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_rgb    (wr_rgb),
      .clr_req   (clr_req),
      .swap_req  (swap_req),
      .swap_done (swap_done),
      .frame     (frame),
      .subframe  (subframe),
      .x         (x),
      .y         (y),
      .rgb       (rgb)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Reference model
   logic          fs_m;
   logic [PW-1:0] mem_m [0:8191];
   logic [2:0]    exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_rgb(input logic [PW-1:0] v, input logic [7:0] sf);
      logic [2:0] r;
      for (int c = 0; c < 3; c++)
         r[c] = (v[c*D +: D] > sf[D-1:0]);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [5:0] px, input logic [5:0] py, input logic [7:0] sf);
      x        = px;
      y        = py;
      subframe = sf;
      exp_q.push_back(exp_rgb(mem_m[{fs_m, py, px}], sf));
      step();
      chk("rgb", 32'(rgb), 32'(exp_q.pop_front()));
   endtask

   task automatic wr(input logic [5:0] px, input logic [5:0] py, input logic [PW-1:0] v);
      wr_valid = 1'b1;
      wr_x     = px;
      wr_y     = py;
      wr_rgb   = v;
      #1;
      chk("wr_ready_idle", 32'(wr_ready), 32'd1);
      mem_m[{~fs_m, py, px}] = v;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic do_swap();
      swap_req = 1'b1;
      #1;
      chk("swap_req_ready", 32'(wr_ready), 32'd1);
      step();
      swap_req = 1'b0;
      frame    = frame + 13'd1;
      #1;
      chk("swap_done_pulse", 32'(swap_done), 32'd1);
      step();
      fs_m = ~fs_m;
      #1;
      chk("swap_done_one_cycle", 32'(swap_done), 32'd0);
      chk("swap_back_idle", 32'(wr_ready), 32'd1);
   endtask

   // Full clear; frame is bumped every cycle to tempt a spurious swap.
   task automatic do_clear(input logic also_swap);
      int cnt, sd;
      bit done;
      cnt = 0; sd = 0; done = 0;
      clr_req  = 1'b1;
      swap_req = also_swap;
      #1;
      chk("clr_req_ready", 32'(wr_ready), 32'd1);
      step();
      clr_req  = 1'b0;
      swap_req = 1'b0;
      wr_valid = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         #1;
         if (swap_done) sd++;
         if (wr_ready) done = 1;
         else begin
            cnt++;
            frame = frame + 13'd1;
            step();
         end
      end
      chk("clr_busy_cycles", 32'(cnt), 32'd4096);
      chk("clr_no_swap", 32'(sd), 32'd0);
      for (int a = 0; a < 4096; a++)
         mem_m[{~fs_m, a[11:0]}] = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      fs_m = 1'b0;
      for (int a = 0; a < 8192; a++) mem_m[a] = '0;
      reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
      clr_req = 1'b0; swap_req = 1'b0; frame = '0; subframe = '0; x = '0; y = '0;

      // Reset state
      repeat (3) step();
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_swap_done", 32'(swap_done), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);

      // First cycle after reset: write accepted, same cycle as a clear
      reset    = 1'b0;
      wr_valid = 1'b1; wr_x = 6'd1; wr_y = 6'd2; wr_rgb = 12'h123;
      mem_m[{~fs_m, 6'd2, 6'd1}] = 12'h123;
      do_clear(1'b0);

      // Bring the cleared bank to the front, clear the other one too
      do_swap();
      do_clear(1'b0);
      for (int a = 0; a < 4096; a++)
         rd(a[5:0], a[11:6], a[7:0]);

      // Basic write / swap / BCM readback (blue=F, green=8, red=0)
      wr(6'd5, 6'd7, 12'hF80);
      do_swap();
      rd(6'd5, 6'd7, 8'd3);
      rd(6'd5, 6'd7, 8'd8);
      rd(6'd5, 6'd7, 8'd15);
      rd(6'd5, 6'd7, 8'h13);
      rd(6'd5, 6'd7, 8'd0);

      // Back-bank write invisible until swap
      wr(6'd5, 6'd7, 12'h5A3);
      rd(6'd5, 6'd7, 8'd8);

      // Swap request on a frame boundary, then frame held for 100 cycles
      // with a write attempt that must be ignored
      swap_req = 1'b1;
      frame    = frame + 13'd1;
      #1;
      chk("swap_edge_ready", 32'(wr_ready), 32'd1);
      step();
      swap_req = 1'b0;
      wr_valid = 1'b1; wr_x = 6'd5; wr_y = 6'd7; wr_rgb = 12'hFFF;
      for (int i = 0; i < 100; i++) begin
         #1;
         chk("hold_wr_ready", 32'(wr_ready), 32'd0);
         chk("hold_swap_done", 32'(swap_done), 32'd0);
         step();
      end
      wr_valid = 1'b0;
      frame    = frame + 13'd1;
      #1;
      chk("late_swap_done", 32'(swap_done), 32'd1);
      chk("late_swap_ready", 32'(wr_ready), 32'd0);
      step();
      fs_m = ~fs_m;
      #1;
      chk("late_swap_idle", 32'(wr_ready), 32'd1);
      rd(6'd5, 6'd7, 8'd4);
      rd(6'd5, 6'd7, 8'd2);

      // Clear and swap together: clear wins, front unchanged
      do_clear(1'b1);
      rd(6'd5, 6'd7, 8'd4);

      // Reset in the middle of a clear
      wr(6'd63, 6'd63, 12'hFFF);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 2000; i++) step();
      #1;
      chk("mid_clr_busy", 32'(wr_ready), 32'd0);
      for (int a = 0; a < 2000; a++)
         mem_m[{~fs_m, a[11:0]}] = '0;
      reset = 1'b1;
      frame = frame + 13'd1;
      #1;
      chk("rst_mid_ready", 32'(wr_ready), 32'd0);
      chk("rst_mid_swap_done", 32'(swap_done), 32'd0);
      step();
      chk("rst_mid_rgb", 32'(rgb), 32'd0);
      reset = 1'b0;
      fs_m  = 1'b0;
      #1;
      chk("post_rst_ready", 32'(wr_ready), 32'd1);
      rd(6'd63, 6'd63, 8'd0);
      rd(6'd5, 6'd7, 8'd0);
      rd(6'd63, 6'd63, 8'd15);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
